shell_ctrl: RTL and testbench

- Per-tank projectile controller: launches a shell on a fire-key press, advances it once per frame and detects collision with the opposing tank.
- Produces the single-cycle shot_hit pulse that game_sm consumes as shot_hit1/shot_hit2, plus the shell position for the renderer.
- Two instances per design, one per tank; fire key is parameterised per instance.

---
 rtl/tank_pkg.sv | 22 ++
 rtl/key_match.sv | 32 +++
 rtl/shell_ctrl.sv | 171 +++++++++++++++++
 tb/tb_shell_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game logic.
// Imported by shell_ctrl and key_match.
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_RIGHT,
    DIR_DOWN,
    DIR_LEFT
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    HIT,
    COOL
  } shell_state_t;

  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_ENTER = 8'h28;

endpackage

// File: rtl/key_match.sv
// Four-slot USB keycode compare with a registered rising-edge detect.
// Shared by the shell and tank movement logic.
module key_match
  import tank_pkg::*;
#(
  parameter logic [7:0] KEY = KEY_SPACE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] keycode,
  output logic        rise
);

  logic pressed;
  logic prev;

  assign pressed = (keycode[31:24] == KEY)
                || (keycode[23:16] == KEY)
                || (keycode[15:8]  == KEY)
                || (keycode[7:0]   == KEY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= pressed;
    end
  end

  assign rise = pressed & ~prev;

endmodule

// File: rtl/shell_ctrl.sv
// Per-tank shell launcher, flight stepper and hit detector.
// Optional SHELL_POWERUP_EN adds a latched double-speed powerup.
module shell_ctrl
  import tank_pkg::*;
#(
  parameter logic [7:0] FIRE_KEY    = KEY_SPACE,
  parameter int         SHELL_SPEED = 4,
  parameter int         TANK_HALF   = 8,
  parameter int         SCREEN_W    = 640,
  parameter int         SCREEN_H    = 480,
  parameter int         COOLDOWN    = 30
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycode,
  input  logic        game_over,
  input  logic [9:0]  tank_x,
  input  logic [9:0]  tank_y,
  input  logic [1:0]  tank_dir,
  input  logic [9:0]  target_x,
  input  logic [9:0]  target_y,
`ifdef SHELL_POWERUP_EN
  input  logic        tank_powerup,
`endif
  output logic [9:0]  shell_x,
  output logic [9:0]  shell_y,
  output logic        shell_active,
  output logic        shot_hit,
  output logic        ready
);

  localparam int CW =
    (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CW-1:0] CD_FULL =
    CW'(COOLDOWN - 1);
  localparam logic signed [10:0] X_LIM =
    11'(SCREEN_W);
  localparam logic signed [10:0] Y_LIM =
    11'(SCREEN_H);
  localparam logic signed [11:0] HALF =
    12'(TANK_HALF);

  shell_state_t       state;
  dir_t               dir_q;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cd_load;
  logic               fire_edge;
  logic signed [10:0] spd;
  logic signed [10:0] sx, sy;
  logic signed [10:0] nx, ny;
  logic signed [11:0] dx, dy;
  logic signed [11:0] adx, ady;
  logic               oob;
  logic               hit;

  key_match #(
    .KEY (FIRE_KEY)
  ) u_fire (
    .clk     (frame_clk),
    .rst_n   (Reset),
    .keycode (keycode),
    .rise    (fire_edge)
  );

`ifdef SHELL_POWERUP_EN
  localparam int CD_HALF_N =
    (COOLDOWN / 2 > 1) ? COOLDOWN / 2 : 1;
  localparam logic [CW-1:0] CD_HALF =
    CW'(CD_HALF_N - 1);

  logic pw_q;

  assign spd = pw_q ? 11'(2 * SHELL_SPEED)
                    : 11'(SHELL_SPEED);
  assign cd_load = pw_q ? CD_HALF : CD_FULL;
`else
  assign spd     = 11'(SHELL_SPEED);
  assign cd_load = CD_FULL;
`endif

  assign sx = {1'b0, shell_x};
  assign sy = {1'b0, shell_y};

  // Screen y grows downward, so "up" subtracts.
  always_comb begin
    nx = sx;
    ny = sy;
    unique case (dir_q)
      DIR_UP:    ny = sy - spd;
      DIR_RIGHT: nx = sx + spd;
      DIR_DOWN:  ny = sy + spd;
      DIR_LEFT:  nx = sx - spd;
    endcase
  end

  assign oob = nx[10] | ny[10]
             | (nx >= X_LIM)
             | (ny >= Y_LIM);

  // One extra bit keeps the difference from wrapping.
  assign dx  = {nx[10], nx} - {2'b00, target_x};
  assign dy  = {ny[10], ny} - {2'b00, target_y};
  assign adx = dx[11] ? -dx : dx;
  assign ady = dy[11] ? -dy : dy;
  assign hit = (adx <= HALF) && (ady <= HALF);

  assign ready = (state == IDLE) && !game_over;

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      dir_q        <= DIR_UP;
      cnt          <= '0;
      shell_x      <= '0;
      shell_y      <= '0;
      shell_active <= 1'b0;
      shot_hit     <= 1'b0;
`ifdef SHELL_POWERUP_EN
      pw_q         <= 1'b0;
`endif
    end else if (game_over) begin
      state        <= IDLE;
      shell_active <= 1'b0;
      shot_hit     <= 1'b0;
    end else begin
      shot_hit <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fire_edge) begin
            state        <= FLY;
            dir_q        <= dir_t'(tank_dir);
            shell_x      <= tank_x;
            shell_y      <= tank_y;
            shell_active <= 1'b1;
`ifdef SHELL_POWERUP_EN
            pw_q         <= tank_powerup;
`endif
          end
        end
        FLY: begin
          if (oob) begin
            state        <= COOL;
            shell_active <= 1'b0;
            cnt          <= cd_load;
          end else if (hit) begin
            state        <= HIT;
            shell_active <= 1'b0;
            shot_hit     <= 1'b1;
            shell_x      <= nx[9:0];
            shell_y      <= ny[9:0];
          end else begin
            shell_x <= nx[9:0];
            shell_y <= ny[9:0];
          end
        end
        HIT: begin
          state <= COOL;
          cnt   <= cd_load;
        end
        COOL: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shell_ctrl.sv
// Directed bench for shell_ctrl: flight vectors
// plus reset, cooldown, held-key and game_over sequences.
module tb_shell_ctrl;
  import tank_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] keycode = '0;
  logic        game_over = 1'b0;
  logic [9:0]  tank_x = '0, tank_y = '0;
  logic [1:0]  tank_dir = '0;
  logic [9:0]  target_x = '0, target_y = '0;
  logic [9:0]  shell_x, shell_y;
  logic        shell_active, shot_hit, ready;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shell_ctrl dut (
    .frame_clk    (clk),
    .Reset        (rst_n),
    .keycode      (keycode),
    .game_over    (game_over),
    .tank_x       (tank_x),
    .tank_y       (tank_y),
    .tank_dir     (tank_dir),
    .target_x     (target_x),
    .target_y     (target_y),
`ifdef SHELL_POWERUP_EN
    .tank_powerup (1'b0),
`endif
    .shell_x      (shell_x),
    .shell_y      (shell_y),
    .shell_active (shell_active),
    .shot_hit     (shot_hit),
    .ready        (ready)
  );

  typedef struct {
    logic [31:0] key;
    int tx, ty, dir, gx, gy;
    int e_act, e_hits, e_x, e_y;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic do_reset();
    keycode   = '0;
    game_over = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic setup(input int tx, input int ty,
                       input int d, input int gx,
                       input int gy);
    tank_x   = 10'(tx);
    tank_y   = 10'(ty);
    tank_dir = 2'(d);
    target_x = 10'(gx);
    target_y = 10'(gy);
  endtask

  task automatic press(input logic [31:0] k);
    keycode = k;
    @(negedge clk);
    keycode = '0;
  endtask

  // Runs until shell_active drops; then watches for stray hits.
  task automatic run_flight(output int act,
                            output int hits,
                            output int dbl,
                            output int fx,
                            output int fy,
                            output int done);
    int ph;
    act = 0; hits = 0; dbl = 0;
    fx = 0; fy = 0; done = 0; ph = 0;
    for (int c = 0; c < 400 && done == 0; c++) begin
      if (shot_hit) begin
        hits++;
        if (ph != 0) dbl = 1;
      end
      ph = int'(shot_hit);
      if (shell_active) begin
        act++;
        @(negedge clk);
      end else begin
        fx = int'(shell_x);
        fy = int'(shell_y);
        done = 1;
      end
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int act, hits, dbl, fx, fy, done;
    int cyc, cnt, launches, prev, t;
    int hcnt, acnt, rcnt;

    vecs[0] = '{32'h0000002C, 100, 240, 1, 140, 240,
                8, 1, 132, 240};
    vecs[1] = '{32'h00002C00, 620, 100, 1, 100, 400,
                5, 0, 636, 100};
    vecs[2] = '{32'h002C0000, 300, 100, 0, 600, 400,
                26, 0, 300, 0};
    vecs[3] = '{32'h2C000000, 300, 400, 2, 300, 440,
                8, 1, 300, 432};
    vecs[4] = '{32'h11222C33, 50, 50, 3, 600, 400,
                13, 0, 2, 50};
    vecs[5] = '{32'h0000002C, 200, 200, 1, 212, 205,
                1, 1, 204, 200};
    vecs[6] = '{32'h0000002C, 636, 100, 1, 645, 100,
                1, 0, 636, 100};
    vecs[7] = '{32'h0000002C, 100, 240, 1, 140, 249,
                135, 0, 636, 240};
    vecs[8] = '{32'h28282828, 100, 100, 1, 900, 900,
                0, 0, 0, 0};

    // Reset state
    do_reset();
    check("rst_active", int'(shell_active), 0);
    check("rst_x", int'(shell_x), 0);
    check("rst_y", int'(shell_y), 0);
    check("rst_hit", int'(shot_hit), 0);
    check("rst_ready", int'(ready), 1);

    // Table-driven flights
    foreach (vecs[i]) begin
      do_reset();
      setup(vecs[i].tx, vecs[i].ty, vecs[i].dir,
            vecs[i].gx, vecs[i].gy);
      press(vecs[i].key);
      check($sformatf("v%0d_ready", i), int'(ready),
            (vecs[i].e_act > 0) ? 0 : 1);
      run_flight(act, hits, dbl, fx, fy, done);
      repeat (3) begin
        @(negedge clk);
        if (shot_hit) hits++;
      end
      check($sformatf("v%0d_done", i), done, 1);
      check($sformatf("v%0d_active", i),
            act, vecs[i].e_act);
      check($sformatf("v%0d_hits", i),
            hits, vecs[i].e_hits);
      check($sformatf("v%0d_dbl", i), dbl, 0);
      check($sformatf("v%0d_x", i), fx, vecs[i].e_x);
      check($sformatf("v%0d_y", i), fy, vecs[i].e_y);
    end

    // Async reset in the middle of a flight
    do_reset();
    setup(300, 200, 1, 900, 900);
    press(32'h0000002C);
    check("mid_x", int'(shell_x), 300);
    check("mid_active", int'(shell_active), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_active", int'(shell_active), 0);
    check("mid_rst_x", int'(shell_x), 0);
    check("mid_rst_y", int'(shell_y), 0);
    check("mid_rst_ready", int'(ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Cooldown length with an ignored fire at cycle 10
    do_reset();
    setup(100, 240, 1, 140, 240);
    press(32'h0000002C);
    run_flight(act, hits, dbl, fx, fy, done);
    check("cool_hit", hits, 1);
    cyc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      cyc++;
      if (ready) break;
      if (cyc == 10) keycode = 32'h0000002C;
      if (cyc == 11) keycode = '0;
    end
    check("cool_len", cyc - 1, 30);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (shell_active) cnt++;
    end
    check("cool_no_queue", cnt, 0);

    // Held key launches once; re-press launches again
    do_reset();
    setup(620, 100, 1, 900, 900);
    keycode = 32'h2C000000;
    launches = 0;
    prev = 0;
    repeat (100) begin
      @(negedge clk);
      if (shell_active && prev == 0) launches++;
      prev = int'(shell_active);
    end
    check("held_launches", launches, 1);
    check("held_ready", int'(ready), 1);
    keycode = '0;
    @(negedge clk);
    press(32'h2C000000);
    check("repress_active", int'(shell_active), 1);

    // game_over on the collision cycle suppresses the hit
    do_reset();
    setup(100, 240, 1, 140, 240);
    press(32'h0000002C);
    t = 0;
    for (int c = 0; c < 20; c++) begin
      if (shell_x == 10'd128) begin
        t = 1;
        break;
      end
      @(negedge clk);
    end
    check("go_reach128", t, 1);
    game_over = 1'b1;
    hcnt = 0; acnt = 0; rcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (shot_hit) hcnt++;
      if (shell_active) acnt++;
      if (ready) rcnt++;
      if (c == 5) keycode = 32'h0000002C;
      if (c == 6) keycode = '0;
    end
    check("go_hits", hcnt, 0);
    check("go_active", acnt, 0);
    check("go_ready_low", rcnt, 0);
    game_over = 1'b0;
    #1;
    check("go_ready_back", int'(ready), 1);
    @(negedge clk);
    check("go_no_launch", int'(shell_active), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
